accum_block: RTL

Parametrised multi-channel block accumulator, successor to the single-channel 8-bit/16-bit summing accumulator. It accepts one sample per cycle, tagged with a channel index, and keeps an independent running sum, sample count and sticky overflow flag for each channel. When a channel has received BLOCK_LEN samples, the block emits that channel's sum through a ready/valid output port and restarts the channel. It sits between sample producers (ADC front-ends, counters) and downstream statistics or averaging logic.

---
 rtl/accum_block.sv | 119 +++++++++++
 1 files changed

// File: rtl/accum_block.sv
// accum_block: multi-channel block accumulator; emits a channel's sum after every BLOCK_LEN samples.
// Build option: define ACC_SIGNED_EN for two's-complement samples/sums (signed overflow and clamping).
module accum_block #(
  parameter int DATA_W    = 8,
  parameter int SUM_W     = 16,
  parameter int CHANNELS  = 4,
  parameter int BLOCK_LEN = 16,
  parameter int CH_W      = $clog2(CHANNELS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              sat_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [SUM_W-1:0]  out_sum,
  output logic              out_ovf
);
  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

  logic [SUM_W-1:0]  acc [CHANNELS];
  logic [CNT_W-1:0]  cnt [CHANNELS];
  logic              ovf [CHANNELS];
  logic              vld_p1;
  logic [CH_W-1:0]   ch_p1;
  logic [SUM_W-1:0]  sum_p1;
  logic              ovf_p1;

  logic              take;
  logic              ch_ok;
  logic [SUM_W:0]    add_res;
  logic              nxt_ovf;

  // Clamp value; in the unsigned build only the upper rail is reachable (neg is always 0).
  function automatic logic [SUM_W-1:0] saturate(input logic neg);
`ifdef ACC_SIGNED_EN
    return neg ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
`else
    return {SUM_W{!neg}};
`endif
  endfunction

  // Returns {overflow, new_sum}.
  function automatic logic [SUM_W:0] add_sample(input logic [SUM_W-1:0] a,
                                                input logic [DATA_W-1:0] d,
                                                input logic sat);
`ifdef ACC_SIGNED_EN
    logic signed [SUM_W-1:0] sa, sd, ss;
    logic o;
    sa = signed'(a);
    sd = SUM_W'(signed'(d));
    ss = sa + sd;
    o  = (sa[SUM_W-1] == sd[SUM_W-1]) && (ss[SUM_W-1] != sa[SUM_W-1]);
    if (o && sat) ss = signed'(saturate(sa[SUM_W-1]));
    return {o, ss};
`else
    logic [SUM_W:0] n;
    n = {1'b0, a} + (SUM_W+1)'(d);
    if (n[SUM_W] && sat) n[SUM_W-1:0] = saturate(1'b0);
    return n;
`endif
  endfunction

  assign in_ready = (!vld_p1 || out_ready) && !clr;
  assign take     = in_valid && in_ready;
  assign ch_ok    = {1'b0, in_ch} < (CH_W+1)'(CHANNELS);
  assign add_res  = add_sample(acc[in_ch], in_data, sat_mode);
  assign nxt_ovf  = ovf[in_ch] | add_res[SUM_W];

  // Stage p0 -> p1: per-channel accumulate, block completion loads the output register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        ovf[i] <= 1'b0;
      end
      vld_p1 <= 1'b0;
      ch_p1  <= '0;
      sum_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else begin
      if (out_ready) vld_p1 <= 1'b0;
      if (clr) begin
        for (int i = 0; i < CHANNELS; i++) begin
          acc[i] <= '0;
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end
      end else if (take && ch_ok) begin
        if (cnt[in_ch] == CNT_LAST) begin
          acc[in_ch] <= '0;
          cnt[in_ch] <= '0;
          ovf[in_ch] <= 1'b0;
          vld_p1     <= 1'b1;
          ch_p1      <= in_ch;
          sum_p1     <= add_res[SUM_W-1:0];
          ovf_p1     <= nxt_ovf;
        end else begin
          acc[in_ch] <= add_res[SUM_W-1:0];
          cnt[in_ch] <= cnt[in_ch] + CNT_W'(1);
          ovf[in_ch] <= nxt_ovf;
        end
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_ch    = ch_p1;
  assign out_sum   = sum_p1;
  assign out_ovf   = ovf_p1;

endmodule
